// File: rtl/fetch_unit_pkg.sv
// Shared types and default sizing for the instruction-fetch slice.
// Build option: FETCH_WRAP_HALT_EN (halt after the last address instead of wrapping).
package cpu_fetch_pkg;

  localparam int DEF_ADDR_W   = 9;
  localparam int DEF_INSTR_W  = 33;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HOLD,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of instruction-memory and decode-side signals around the fetch unit.
// Master is the fetch unit; slave is the memory/decode environment.
interface fetch_unit_if #(
  parameter int ADDR_W  = cpu_fetch_pkg::DEF_ADDR_W,
  parameter int INSTR_W = cpu_fetch_pkg::DEF_INSTR_W
);

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_q;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               halted;

  modport master (
    output imem_addr,
    input  imem_q,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output instr,
    output instr_pc,
    output instr_valid,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_q,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    input  halted
  );

endinterface

// File: rtl/fetch_unit_hold_reg.sv
// Back-pressure capture register plus the decode-side output mux keyed on fetch state.
module fetch_hold_reg
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  fetch_state_t       state_i,
  input  logic               capture_i,
  input  logic               squash_i,
  input  logic [INSTR_W-1:0] imem_q_i,
  input  logic [ADDR_W-1:0]  pendPc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instrPc_o,
  output logic               instrValid_o
);

  logic [INSTR_W-1:0] holdInstr_q;
  logic [ADDR_W-1:0]  holdPc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      holdInstr_q <= '0;
      holdPc_q    <= '0;
    end else if (capture_i) begin
      holdInstr_q <= imem_q_i;
      holdPc_q    <= pendPc_i;
    end
  end

  always_comb begin
    instr_o      = '0;
    instrPc_o    = '0;
    instrValid_o = 1'b0;
    case (state_i)
      RUN: begin
        instr_o      = imem_q_i;
        instrPc_o    = pendPc_i;
        instrValid_o = 1'b1;
      end
      HOLD: begin
        instr_o      = holdInstr_q;
        instrPc_o    = holdPc_q;
        instrValid_o = 1'b1;
      end
      default: ;
    endcase
    // A redirect makes whatever is on the output stale, so decode must not take it.
    if (squash_i) begin
      instrValid_o = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: PC sequencing, redirect handling and fill/run/hold FSM.
// Build option: FETCH_WRAP_HALT_EN stops fetch after the top address instead of wrapping.
module fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
  logic [ADDR_W-1:0] pendPc_q, pendPc_d;
  logic              capture;
  logic              advance;

`ifdef FETCH_WRAP_HALT_EN
  localparam logic [ADDR_W-1:0] LAST_PC = '1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FILL;
      fetchPc_q <= ADDR_W'(RESET_PC);
      pendPc_q  <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      pendPc_q  <= pendPc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    pendPc_d  = pendPc_q;
    capture   = 1'b0;
    advance   = 1'b0;

    if (bus.redirect_valid) begin
      fetchPc_d = bus.redirect_pc;
      state_d   = FILL;
    end else begin
      case (state_q)
        FILL: advance = 1'b1;
        RUN: begin
          if (bus.stall) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            advance = 1'b1;
          end
        end
        HOLD:    advance = !bus.stall;
        default: ;
      endcase
    end

    // The word at imem_addr this cycle lands on imem_q next cycle, so it becomes pending.
    if (advance) begin
`ifdef FETCH_WRAP_HALT_EN
      if (state_q != FILL && pendPc_q == LAST_PC) begin
        state_d = HALT;
      end else begin
        pendPc_d = fetchPc_q;
        state_d  = RUN;
        if (fetchPc_q != LAST_PC) begin
          fetchPc_d = fetchPc_q + ADDR_W'(1);
        end
      end
`else
      pendPc_d  = fetchPc_q;
      fetchPc_d = fetchPc_q + ADDR_W'(1);
      state_d   = RUN;
`endif
    end
  end

  assign bus.imem_addr = fetchPc_q;

`ifdef FETCH_WRAP_HALT_EN
  assign bus.halted = (state_q == HALT);
`else
  assign bus.halted = 1'b0;
`endif

  fetch_hold_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_hold (
    .clock        (clock),
    .reset        (reset),
    .state_i      (state_q),
    .capture_i    (capture),
    .squash_i     (bus.redirect_valid),
    .imem_q_i     (bus.imem_q),
    .pendPc_i     (pendPc_q),
    .instr_o      (bus.instr),
    .instrPc_o    (bus.instr_pc),
    .instrValid_o (bus.instr_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a stream-level model of the
// delivered instruction sequence (next pc to deliver, bubbles pending, halted).
module tb_fetch_unit;
  import cpu_fetch_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int IW    = DEF_INSTR_W;
  localparam int DEPTH = 1 << AW;
`ifdef FETCH_WRAP_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_unit #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .RESET_PC (DEF_RESET_PC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [IW-1:0] mem [0:DEPTH-1];

  // Synchronous-read instruction memory with one cycle of latency.
  always @(posedge clock) bus.imem_q <= mem[bus.imem_addr];

  int checks   = 0;
  int failures = 0;

  int m_cur;
  int m_gap;
  bit m_halted;

  function automatic logic [IW-1:0] wordOf(input int a);
    logic [IW-1:0] base;
    base = 33'h1_0000_0000;
    return base | IW'(a % DEPTH);
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare this cycle's outputs with the model, then let the model absorb this cycle's inputs.
  task automatic checkOutput(input bit st, input bit rv, input int rpc, input bit rst);
    if (rst) begin
      m_gap    = 1;
      m_cur    = DEF_RESET_PC % DEPTH;
      m_halted = 1'b0;
      return;
    end
    checkVal("halted", 64'(bus.halted), 64'(m_halted));
    if (rv) begin
      checkVal("valid_on_redirect", 64'(bus.instr_valid), 64'd0);
      m_gap    = 1;
      m_cur    = rpc % DEPTH;
      m_halted = 1'b0;
    end else if (m_halted || m_gap > 0) begin
      checkVal("valid_bubble", 64'(bus.instr_valid), 64'd0);
      checkVal("instr_bubble", 64'(bus.instr), 64'd0);
      checkVal("pc_bubble", 64'(bus.instr_pc), 64'd0);
      if (m_gap > 0) m_gap--;
    end else begin
      checkVal("valid", 64'(bus.instr_valid), 64'd1);
      checkVal("instr_pc", 64'(bus.instr_pc), 64'(m_cur));
      checkVal("instr", 64'(bus.instr), 64'(wordOf(m_cur)));
      if (!st) begin
        if (HALT_EN && m_cur == DEPTH - 1) m_halted = 1'b1;
        else m_cur = (m_cur + 1) % DEPTH;
      end
    end
  endtask

  task automatic applyStimulus(input bit st, input bit rv, input int rpc, input bit rst);
    @(negedge clock);
    reset              = rst;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = AW'(rpc);
    #1;
    checkOutput(st, rv, rpc, rst);
  endtask

  // Run with no stall until the model says the given pc is the next one presented.
  task automatic runUntilPc(input int pc);
    int n;
    n = 0;
    while (!(m_gap == 0 && !m_halted && m_cur == pc) && n < 1100) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
      n++;
    end
    if (n >= 1100) begin
      checks++;
      failures++;
      $display("[TB] FAIL runUntilPc timeout observed=none expected=pc %0d", pc);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = wordOf(i);
    reset              = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    m_cur              = 0;
    m_gap              = 1;
    m_halted           = 1'b0;

    $display("[TB] reset and straight-line fetch");
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    runUntilPc(4);

    $display("[TB] stall for three cycles at pc 4");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    runUntilPc(7);

    $display("[TB] redirect to 100 at pc 7");
    applyStimulus(1'b0, 1'b1, 100, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);

    $display("[TB] redirect to 200 while holding");
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 200, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);

    $display("[TB] top-of-memory behaviour");
    applyStimulus(1'b0, 1'b1, 510, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 3, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);

    $display("[TB] reset while holding at pc 20");
    runUntilPc(20);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      int r;
      int rpc;
      bit st;
      r   = $urandom_range(0, 99);
      st  = ($urandom_range(0, 3) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? $urandom_range(505, 511) : $urandom_range(0, 511);
      applyStimulus(st, (r >= 2 && r < 8), rpc, (r < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch initiator that drives the instruction memory's 9-bit synchronous-read port.
- Consumes the 33-bit read data (1-cycle read latency).
- Maintains the PC and presents a valid/stall instruction stream, with PC tags, to decode.
- Handles consumer back-pressure with a hold register and accepts branch/jump redirects.

Parameters:
ADDR_W, 9, instruction address width (memory depth 2^ADDR_W words)
INSTR_W, 33, instruction word width
RESET_PC, 0, first address fetched after reset

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_addr  out  ADDR_W  read address to instruction memory; registered
imem_q  in  INSTR_W  read data; equals mem[imem_addr of previous cycle]
stall  in  1  decode not accepting; current output is not consumed
redirect_valid  in  1  load new PC; squashes in-flight fetch
redirect_pc  in  ADDR_W  redirect target
instr  out  INSTR_W  instruction to decode
instr_pc  out  ADDR_W  address of instr
instr_valid  out  1  instr/instr_pc meaningful
halted  out  1  fetch stopped (feature-dependent; 0 when feature absent)

Behaviour:
- Registers:
  - fetch_pc: drives imem_addr.
  - pend_pc: address whose data is on imem_q.
  - hold_instr and hold_pc.
  - state.
- States:
  - FILL: no valid data on imem_q.
  - RUN: imem_q valid for pend_pc.
  - HOLD: output from hold register.
  - HALT: feature only.
- Reset: fetch_pc=RESET_PC, state=FILL, hold_instr=0, hold_pc=0, pend_pc=0, halted=0. Outputs during the reset cycle and the first FILL cycle: instr_valid=0, instr=0, instr_pc=0.
- Output mux:
  - RUN: instr=imem_q, instr_pc=pend_pc, instr_valid=1.
  - HOLD: instr=hold_instr, instr_pc=hold_pc, instr_valid=1.
  - FILL/HALT: instr_valid=0, instr=0, instr_pc=0.
- Advance (FILL always; RUN/HOLD when !stall): pend_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^ADDR_W), state<=RUN.
- RUN with stall:
  - Capture hold_instr<=imem_q and hold_pc<=pend_pc.
  - fetch_pc is not advanced; state<=HOLD.
- HOLD with stall: everything held; outputs stable for any number of cycles.
- HOLD with !stall: the held word is consumed this cycle, then advance. Next cycle imem_q=mem[old fetch_pc], so the stream stays gapless.
- Latency:
  - First valid instruction (RESET_PC) appears 1 cycle after reset deasserts.
  - Steady state delivers 1 instr/cycle with no bubbles.
- Redirect (priority over stall, any state including HOLD/HALT):
  - In the redirect cycle, instr_valid is forced 0.
  - fetch_pc<=redirect_pc, state<=FILL, halted<=0.
  - The target instruction is valid 2 cycles after the redirect cycle (1 bubble).
- Stall while instr_valid=0 has no effect on fill progress.
- Reset mid-operation (any state) returns to the reset values next edge and discards the hold register.

Optional Feature:
Macro FETCH_WRAP_HALT_EN.
- Defined:
  - An advance with fetch_pc = 2^ADDR_W-1 issues that last address, then enters HALT after the word is delivered: RUN→HALT on the accepting cycle.
  - In HALT: imem_addr frozen, instr_valid=0, halted=1.
  - Only redirect or reset exit HALT.
- Undefined: fetch_pc wraps 511→0 silently; HALT state unused; halted tied 0.

Decomposition:
- Package cpu_fetch_pkg contains:
  - ADDR_W/INSTR_W defaults and RESET_PC.
  - fetch_state_t enum {FILL, RUN, HOLD, HALT}.
- Natural sub-module: fetch_hold_reg, the capture/hold register plus output mux keyed on state.
- PC/FSM logic stays in the top.

Test Plan:
- Memory model word i = 33'h1_0000_0000|i. Release reset, stall=0: cycle1 instr=33'h1_0000_0000 with pc 0; consecutive cycles pc 1,2,3… with no gaps.
- Assert stall for 3 cycles while instr_pc=4: instr/pc held at word 4/pc 4 all 3 cycles. On release, pc 4 is consumed, then 5, 6, with none skipped or duplicated.
- redirect_valid with redirect_pc=100 while at pc 7: instr_valid=0 that cycle and the next; following cycle instr_pc=100, instr=33'h1_0000_0064.
- Redirect to 200 while in HOLD with stall=1: hold is discarded, and pc 200 is delivered 2 cycles later once stall drops.
- Redirect to 510, stream runs:
  - Without macro: pcs 510, 511, 0, 1.
  - With FETCH_WRAP_HALT_EN: pcs 510, 511, then instr_valid=0 and halted=1 persisting; redirect to 3 clears halted and delivers pc 3.
- Assert reset during HOLD at pc 20: next cycle instr_valid=0 and state FILL; pc 0 is delivered 1 cycle after reset release.
